// File: rtl/latch_sched_pkg.sv
// Shared types and default sizing for the latch bank write scheduler.
// Imported by the arbiter and the scheduler top.
package latch_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    OPEN  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam int NREQ_D     = 4;
  localparam int W_D        = 8;
  localparam int DEPTH_D    = 4;
  localparam int AW_D       = 2;
  localparam int OPEN_CYC_D = 1;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requester at or after ptr+1, one-hot grant.
// Purely combinational; the pointer register lives in the parent.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   gnt_idx,
  output logic            any
);

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      if (!any && req[(int'(ptr) + i) % NREQ]) begin
        any = 1'b1;
        gnt[(int'(ptr) + i) % NREQ] = 1'b1;
        gnt_idx = PW'((int'(ptr) + i) % NREQ);
      end
    end
  end

endmodule

// File: rtl/latch_write_sched.sv
// Latch bank write scheduler: round-robin grant, then SETUP/OPEN/HOLD
// so latch data is stable around every enable pulse.
module latch_write_sched
  import latch_sched_pkg::*;
#(
  parameter int NREQ     = NREQ_D,
  parameter int W        = W_D,
  parameter int DEPTH    = DEPTH_D,
  parameter int AW       = AW_D,
  parameter int OPEN_CYC = OPEN_CYC_D
) (
  input  logic              Clk,
  input  logic              R,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] wdata,
  input  logic [NREQ*AW-1:0] waddr,
  output logic [NREQ-1:0]   ack,
  output logic              busy,
  output logic              err,
  output logic [DEPTH-1:0]  latch_en,
  output logic [W-1:0]      latch_d
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(OPEN_CYC + 1);
  localparam logic [CW-1:0] CLAST = CW'(OPEN_CYC - 1);

  state_t            state, next;
  logic [PW-1:0]     ptr, win_idx, gnt_idx;
  logic [NREQ-1:0]   gnt, win_oh;
  logic              any;
  logic [AW-1:0]     addr, cap_a;
  logic [W-1:0]      cap_d;
  logic [CW-1:0]     cnt;
  logic [DEPTH-1:0]  en_dec;
  logic              bad;

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .req     (req),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  always_comb begin
    cap_a = '0;
    cap_d = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        cap_a = waddr[i*AW +: AW];
        cap_d = wdata[i*W +: W];
      end
    end
  end

  // Out-of-range addresses decode to no enable at all.
  always_comb begin
    en_dec = '0;
    for (int k = 0; k < DEPTH; k++) begin
      en_dec[k] = (int'(addr) == k);
    end
    bad = (int'(addr) >= DEPTH);
  end

  always_ff @(posedge Clk or posedge R) begin
    if (R) state <= IDLE;
    else   state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE:  if (any) next = SETUP;
      SETUP: next = OPEN;
      OPEN:  if (cnt == CLAST) next = HOLD;
      HOLD:  next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge R) begin
    if (R) begin
      ptr      <= PW'(NREQ - 1);
      win_idx  <= '0;
      win_oh   <= '0;
      addr     <= '0;
      cnt      <= '0;
      latch_en <= '0;
      latch_d  <= '0;
      ack      <= '0;
      err      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      busy <= (next != IDLE);
      ack  <= '0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any) begin
            win_idx <= gnt_idx;
            win_oh  <= gnt;
            addr    <= cap_a;
            latch_d <= cap_d;
          end
        end
        SETUP: begin
          latch_en <= en_dec;
          cnt      <= '0;
        end
        OPEN: begin
          if (cnt == CLAST) begin
            latch_en <= '0;
            ack      <= win_oh;
            err      <= bad;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        HOLD: ptr <= win_idx;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_latch_write_sched.sv
// Randomized bench for latch_write_sched against a transaction timeline
// model: each grant schedules its expected outputs by cycle number.
module tb_latch_write_sched;

  localparam int NREQ  = 4;
  localparam int W     = 8;
  localparam int DEPTH = 3;
  localparam int AW    = 2;
  localparam int OC    = 1;
  localparam int MAXC  = 4096;

  logic              Clk = 1'b0;
  logic              R;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] wdata;
  logic [NREQ*AW-1:0] waddr;
  logic [NREQ-1:0]   ack;
  logic              busy;
  logic              err;
  logic [DEPTH-1:0]  latch_en;
  logic [W-1:0]      latch_d;

  latch_write_sched #(
    .NREQ(NREQ), .W(W), .DEPTH(DEPTH), .AW(AW), .OPEN_CYC(OC)
  ) dut (
    .Clk      (Clk),
    .R        (R),
    .req      (req),
    .wdata    (wdata),
    .waddr    (waddr),
    .ack      (ack),
    .busy     (busy),
    .err      (err),
    .latch_en (latch_en),
    .latch_d  (latch_d)
  );

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [DEPTH-1:0] e_en  [MAXC];
  logic [NREQ-1:0]  e_ack [MAXC];
  logic             e_err [MAXC];
  logic             e_bsy [MAXC];
  logic [W-1:0]     e_d   [MAXC];

  int free_at = 0;
  int ptr = NREQ - 1;
  int m_w, m_a;
  logic [W-1:0] m_d;
  logic [16:0] got, want;

  task automatic model_clear(input int from);
    for (int k = from; k < MAXC; k++) begin
      e_en[k] = '0; e_ack[k] = '0; e_err[k] = 1'b0;
      e_bsy[k] = 1'b0; e_d[k] = '0;
    end
  endtask

  always @(posedge R) begin
    model_clear(cyc);
    free_at = 0;
    ptr = NREQ - 1;
  end

  // A grant at edge c: data from c, enable c+1..c+OC, ack at c+OC+1.
  always @(posedge Clk) begin
    cyc++;
    if (!R && cyc >= free_at && req != '0 && cyc + OC + 3 < MAXC) begin
      m_w = -1;
      for (int i = 1; i <= NREQ; i++)
        if (m_w < 0 && req[(ptr + i) % NREQ]) m_w = (ptr + i) % NREQ;
      m_a = int'(waddr[m_w*AW +: AW]);
      m_d = wdata[m_w*W +: W];
      for (int k = cyc; k < MAXC; k++) e_d[k] = m_d;
      for (int k = cyc; k <= cyc + OC + 1; k++) e_bsy[k] = 1'b1;
      for (int k = cyc + 1; k <= cyc + OC; k++)
        e_en[k] = (m_a < DEPTH) ? DEPTH'(1 << m_a) : '0;
      e_ack[cyc + OC + 1] = NREQ'(1 << m_w);
      e_err[cyc + OC + 1] = (m_a >= DEPTH);
      free_at = cyc + OC + 3;
      ptr = m_w;
    end
  end

  task automatic rand_bus();
    wdata = {$urandom, $urandom};
    waddr = NREQ*AW'($urandom);
  endtask

  task automatic test_reset();
    R = 1'b1; req = '0; rand_bus();
    repeat (2) @(negedge Clk);
    checks++;
    if ({latch_en, ack, err, busy, latch_d} !== 17'd0) begin
      errors++;
      $display("FAIL reset_hold got=%h want=0", {latch_en, ack, err, busy, latch_d});
    end
    R = 1'b0;
    repeat (10) begin
      @(negedge Clk);
      got  = {latch_en, ack, err, busy, latch_d};
      want = {e_en[cyc], e_ack[cyc], e_err[cyc], e_bsy[cyc], e_d[cyc]};
      checks++;
      if (got !== want || got !== 17'd0) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d got=%h want=%h", cyc, got, want);
      end
      rand_bus();
    end
  endtask

  task automatic test_single();
    int s, ack_at, en_n;
    s = cyc; ack_at = -1; en_n = 0;
    req = 4'b0100;
    waddr[2*AW +: AW] = 2'd1;
    wdata[2*W +: W] = 8'hA5;
    repeat (8) begin
      @(negedge Clk);
      got  = {latch_en, ack, err, busy, latch_d};
      want = {e_en[cyc], e_ack[cyc], e_err[cyc], e_bsy[cyc], e_d[cyc]};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL single cyc=%0d got=%h want=%h", cyc, got, want);
      end
      if (latch_en == 3'b010) en_n++;
      if (ack == 4'b0100 && !err) begin ack_at = cyc; req = '0; end
      rand_bus();
    end
    checks++;
    if (en_n != 1 || ack_at != s + 3) begin
      errors++;
      $display("FAIL single_timing en_cycles=%0d ack_at=%0d want 1 and %0d", en_n, ack_at, s + 3);
    end
  endtask

  task automatic test_contention();
    int order[$];
    int at[$];
    R = 1'b1; @(negedge Clk); R = 1'b0;
    req = 4'b1111;
    for (int n = 0; n < 40 && order.size() < 4; n++) begin
      @(negedge Clk);
      got  = {latch_en, ack, err, busy, latch_d};
      want = {e_en[cyc], e_ack[cyc], e_err[cyc], e_bsy[cyc], e_d[cyc]};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL contention cyc=%0d got=%h want=%h", cyc, got, want);
      end
      checks++;
      if ($countones(latch_en) > 1) begin
        errors++;
        $display("FAIL contention_onehot got=%b want at most one bit", latch_en);
      end
      for (int i = 0; i < NREQ; i++)
        if (ack[i]) begin order.push_back(i); at.push_back(cyc); req[i] = 1'b0; end
      rand_bus();
    end
    checks++;
    if (order.size() != 4) begin
      errors++;
      $display("FAIL contention_count got=%0d want=4", order.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (order[i] != i || (i > 0 && at[i] - at[i-1] != OC + 3)) begin
          errors++;
          $display("FAIL contention_order idx=%0d got=%0d gap=%0d want=%0d gap=%0d",
                   i, order[i], (i > 0) ? at[i] - at[i-1] : 0, i, OC + 3);
        end
      end
    end
  endtask

  task automatic test_fairness();
    int n_ack;
    n_ack = 0;
    req = 4'b1001;
    for (int n = 0; n < 60 && n_ack < 8; n++) begin
      @(negedge Clk);
      got  = {latch_en, ack, err, busy, latch_d};
      want = {e_en[cyc], e_ack[cyc], e_err[cyc], e_bsy[cyc], e_d[cyc]};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL fairness cyc=%0d got=%h want=%h", cyc, got, want);
      end
      if (ack != '0) begin
        checks++;
        if (ack !== ((n_ack % 2 == 0) ? 4'b0001 : 4'b1000)) begin
          errors++;
          $display("FAIL fairness_alt n=%0d got=%b want=%b", n_ack, ack,
                   (n_ack % 2 == 0) ? 4'b0001 : 4'b1000);
        end
        n_ack++;
      end
      rand_bus();
    end
    req = '0;
    checks++;
    if (n_ack != 8) begin
      errors++;
      $display("FAIL fairness_count got=%0d want=8", n_ack);
    end
  endtask

  task automatic test_bad_addr();
    int hit;
    hit = 0;
    repeat (2) @(negedge Clk);
    req = 4'b0010;
    waddr[1*AW +: AW] = 2'd3;
    repeat (8) begin
      @(negedge Clk);
      got  = {latch_en, ack, err, busy, latch_d};
      want = {e_en[cyc], e_ack[cyc], e_err[cyc], e_bsy[cyc], e_d[cyc]};
      checks++;
      if (got !== want || latch_en !== '0) begin
        errors++;
        $display("FAIL bad_addr cyc=%0d got=%h want=%h", cyc, got, want);
      end
      if (ack == 4'b0010 && err) begin hit++; req = '0; end
      rand_bus();
      if (req[1]) waddr[1*AW +: AW] = 2'd3;
    end
    checks++;
    if (hit != 1) begin
      errors++;
      $display("FAIL bad_addr_err got=%0d want=1 ack+err pulses", hit);
    end
  endtask

  task automatic test_reset_open();
    bit seen;
    seen = 0;
    repeat (2) @(negedge Clk);
    req = 4'b0001;
    waddr[0 +: AW] = 2'd0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge Clk);
      got  = {latch_en, ack, err, busy, latch_d};
      want = {e_en[cyc], e_ack[cyc], e_err[cyc], e_bsy[cyc], e_d[cyc]};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL rst_open_pre cyc=%0d got=%h want=%h", cyc, got, want);
      end
      if (latch_en == 3'b001) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL rst_open_wait got=no enable want=001");
    end
    #2 R = 1'b1;
    #1;
    checks++;
    if (latch_en !== '0 || ack !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_open_async got en=%b ack=%b busy=%b want 0 0 0", latch_en, ack, busy);
    end
    @(negedge Clk);
    R = 1'b0;
    seen = 0;
    for (int n = 0; n < 12 && !seen; n++) begin
      @(negedge Clk);
      got  = {latch_en, ack, err, busy, latch_d};
      want = {e_en[cyc], e_ack[cyc], e_err[cyc], e_bsy[cyc], e_d[cyc]};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL rst_open_post cyc=%0d got=%h want=%h", cyc, got, want);
      end
      if (ack == 4'b0001) begin seen = 1; req = '0; end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL rst_open_reserve got=no ack want=0001");
    end
  endtask

  task automatic test_random();
    req = '0;
    repeat (300) begin
      @(negedge Clk);
      got  = {latch_en, ack, err, busy, latch_d};
      want = {e_en[cyc], e_ack[cyc], e_err[cyc], e_bsy[cyc], e_d[cyc]};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL random cyc=%0d got=%h want=%h", cyc, got, want);
      end
      for (int i = 0; i < NREQ; i++) begin
        if (ack[i]) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(3) == 0) req[i] = 1'b1;
      end
      rand_bus();
    end
    req = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear(0);
    req = '0;
    rand_bus();
    R = 1'b0;
    #1;
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_bad_addr();
    test_reset_open();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
